// File: rtl/noc_local_agent.sv
// -----------------------------------------------------------------------------
// noc_params: shared NoC types used by the mesh routers and their local agents.
//
// noc_local_agent: traffic agent attached to one router's local port.
//   Injector: turns {dest, length, seed} commands into HEAD/BODY/TAIL (or a
//   single HEADTAIL) flit sequence on one router input VC. It waits for an
//   allocatable VC, then sends one flit per cycle while that VC's on/off
//   credit is high.
//   Checker: sinks ejected flits, counts flits and packets, and raises a
//   sticky per-VC error on framing violations or misrouted HEADs.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               packet command (valid/ready handshake)
//   data_o, is_valid_o  flit to router local input
//   is_on_off_i         per-VC space available at router input
//   is_allocatable_i    per-VC free for a new packet at router input
//   ej_data_i/valid_i   flit ejected by the router
//   sink_stall_i        force back-pressure toward the router
//   ej_on_off_o         per-VC on/off back to the router
//   ej_allocatable_o    per-VC allocatable back to the router
//   tx_pkt_cnt_o        packets fully injected
//   rx_flit_cnt_o       flits ejected
//   rx_pkt_cnt_o        packets completed (TAIL or HEADTAIL)
//   err_o               sticky per-VC protocol/routing error
// -----------------------------------------------------------------------------
package noc_params;
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

module noc_local_agent
    import noc_params::*;
#(
    parameter int X_CURRENT   = 0,
    parameter int Y_CURRENT   = 0,
    parameter int PKT_LEN_MAX = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]        cmd_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]        cmd_y_dest_i,
    input  logic [$clog2(PKT_LEN_MAX+1)-1:0]   cmd_len_i,
    input  logic [FLIT_DATA_SIZE-1:0]          cmd_seed_i,
    output flit_t                              data_o,
    output logic                               is_valid_o,
    input  logic [VC_NUM-1:0]                  is_on_off_i,
    input  logic [VC_NUM-1:0]                  is_allocatable_i,
    input  flit_t                              ej_data_i,
    input  logic                               ej_valid_i,
    input  logic                               sink_stall_i,
    output logic [VC_NUM-1:0]                  ej_on_off_o,
    output logic [VC_NUM-1:0]                  ej_allocatable_o,
    output logic [CNT_WIDTH-1:0]               tx_pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]               rx_flit_cnt_o,
    output logic [CNT_WIDTH-1:0]               rx_pkt_cnt_o,
    output logic [VC_NUM-1:0]                  err_o
);

    localparam int LEN_W = $clog2(PKT_LEN_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALLOC = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    // ------------------------------------------------------------------ injector
    logic [1:0]                  state_q;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_q;
    logic [FLIT_DATA_SIZE-1:0]   seed_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            k_q;
    logic [VC_SIZE-1:0]          vc_q;

    logic [LEN_W-1:0]            len_eff;
    logic [VC_SIZE-1:0]          alloc_vc;
    logic                        last_flit;
    flit_t                       flit_next;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign last_flit   = (k_q == len_q - LEN_W'(1));

    // Zero-length commands still produce a packet (one HEADTAIL); oversize
    // commands are clamped rather than rejected.
    always_comb begin
        if (cmd_len_i == '0)
            len_eff = LEN_W'(1);
        else if (cmd_len_i > LEN_W'(PKT_LEN_MAX))
            len_eff = LEN_W'(PKT_LEN_MAX);
        else
            len_eff = cmd_len_i;
    end

    // Lowest allocatable VC wins: scan downward so the last hit is the lowest.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, otherwise
        // paths that skip the assignment infer a latch.
        alloc_vc = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (is_allocatable_i[i])
                alloc_vc = VC_SIZE'(i);
        end
    end

    always_comb begin
        flit_next       = '0;
        flit_next.vc_id = vc_q;
        if (k_q == '0) begin
            flit_next.flit_label             = (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
            flit_next.data.head_data.x_dest  = x_dest_q;
            flit_next.data.head_data.y_dest  = y_dest_q;
            flit_next.data.head_data.head_pl = seed_q[HEAD_PAYLOAD_SIZE-1:0];
        end else begin
            flit_next.flit_label = last_flit ? TAIL : BODY;
            flit_next.data.bt_pl = seed_q + FLIT_DATA_SIZE'(k_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_dest_q     <= '0;
            y_dest_q     <= '0;
            seed_q       <= '0;
            len_q        <= LEN_W'(1);
            k_q          <= '0;
            vc_q         <= '0;
            data_o       <= '0;
            is_valid_o   <= 1'b0;
            tx_pkt_cnt_o <= '0;
        end else begin
            // A flit is valid only in the cycle it is registered; bubbles and
            // non-SEND states present is_valid_o low while data_o holds.
            is_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        x_dest_q <= cmd_x_dest_i;
                        y_dest_q <= cmd_y_dest_i;
                        seed_q   <= cmd_seed_i;
                        len_q    <= len_eff;
                        state_q  <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (|is_allocatable_i) begin
                        vc_q    <= alloc_vc;
                        k_q     <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (is_on_off_i[vc_q]) begin
                        data_o     <= flit_next;
                        is_valid_o <= 1'b1;
                        k_q        <= k_q + LEN_W'(1);
                        if (last_flit) begin
                            state_q      <= ST_IDLE;
                            tx_pkt_cnt_o <= tx_pkt_cnt_o + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ checker
    logic [VC_NUM-1:0]  open_q;
    logic [VC_SIZE-1:0] ej_vc;
    logic               ej_dest_ok;
    logic               unused_ej_pl;

    assign ej_vc      = ej_data_i.vc_id;
    assign ej_dest_ok = (ej_data_i.data.head_data.x_dest == DEST_ADDR_SIZE_X'(X_CURRENT)) &&
                        (ej_data_i.data.head_data.y_dest == DEST_ADDR_SIZE_Y'(Y_CURRENT));
    // The checker validates framing and routing only; head payload is ignored.
    assign unused_ej_pl = ^ej_data_i.data.head_data.head_pl;

    assign ej_on_off_o      = {VC_NUM{~sink_stall_i}};
    assign ej_allocatable_o = ~open_q;

    // The sink accepts every valid flit even while stalling; the stall only
    // shapes the back-pressure seen by the router.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q        <= '0;
            err_o         <= '0;
            rx_flit_cnt_o <= '0;
            rx_pkt_cnt_o  <= '0;
        end else if (ej_valid_i) begin
            rx_flit_cnt_o <= rx_flit_cnt_o + CNT_WIDTH'(1);
            case (ej_data_i.flit_label)
                HEAD: begin
                    if (open_q[ej_vc] || !ej_dest_ok)
                        err_o[ej_vc] <= 1'b1;
                    open_q[ej_vc] <= 1'b1;
                end
                HEADTAIL: begin
                    if (open_q[ej_vc] || !ej_dest_ok)
                        err_o[ej_vc] <= 1'b1;
                    rx_pkt_cnt_o <= rx_pkt_cnt_o + CNT_WIDTH'(1);
                end
                TAIL: begin
                    if (!open_q[ej_vc])
                        err_o[ej_vc] <= 1'b1;
                    open_q[ej_vc] <= 1'b0;
                    rx_pkt_cnt_o  <= rx_pkt_cnt_o + CNT_WIDTH'(1);
                end
                BODY: begin
                    if (!open_q[ej_vc])
                        err_o[ej_vc] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_agent.sv
// -----------------------------------------------------------------------------
// Testbench for noc_local_agent. The agent sits at (1,2); in loopback mode its
// injected flits are fed straight back into its own sink, otherwise the bench
// drives ejected flits directly.
// -----------------------------------------------------------------------------
module tb_noc_local_agent;
    import noc_params::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_x, cmd_y;
    logic [3:0]            cmd_len;
    logic [15:0]           cmd_seed;
    flit_t                 data_o;
    logic                  is_valid_o;
    logic [VC_NUM-1:0]     is_on_off, is_allocatable;
    flit_t                 ej_data, tb_ej_data;
    logic                  ej_valid, tb_ej_valid;
    logic                  sink_stall;
    logic [VC_NUM-1:0]     ej_on_off, ej_allocatable, err;
    logic [15:0]           tx_pkt_cnt, rx_flit_cnt, rx_pkt_cnt;
    logic                  loopback;

    int total = 0;
    int bad   = 0;
    flit_t got_q[$];

    assign ej_data  = loopback ? data_o     : tb_ej_data;
    assign ej_valid = loopback ? is_valid_o : tb_ej_valid;

    always #5 clk = ~clk;

    noc_local_agent #(
        .X_CURRENT(1), .Y_CURRENT(2), .PKT_LEN_MAX(8), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_x_dest_i(cmd_x), .cmd_y_dest_i(cmd_y),
        .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
        .data_o(data_o), .is_valid_o(is_valid_o),
        .is_on_off_i(is_on_off), .is_allocatable_i(is_allocatable),
        .ej_data_i(ej_data), .ej_valid_i(ej_valid),
        .sink_stall_i(sink_stall),
        .ej_on_off_o(ej_on_off), .ej_allocatable_o(ej_allocatable),
        .tx_pkt_cnt_o(tx_pkt_cnt), .rx_flit_cnt_o(rx_flit_cnt),
        .rx_pkt_cnt_o(rx_pkt_cnt), .err_o(err)
    );

    typedef struct {
        logic [1:0]  x, y;
        logic [3:0]  len;
        logic [15:0] seed;
        int          exp_n;
        logic [15:0] exp_last_data;
        flit_label_t exp_last_label;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic flit_t model_flit(input logic [1:0] x, input logic [1:0] y, input int n,
                                         input logic [15:0] seed, input int k, input logic [1:0] vc);
        flit_t f;
        f       = '0;
        f.vc_id = vc;
        if (k == 0) begin
            f.flit_label             = (n == 1) ? HEADTAIL : HEAD;
            f.data.head_data.x_dest  = x;
            f.data.head_data.y_dest  = y;
            f.data.head_data.head_pl = seed[11:0];
        end else begin
            f.flit_label = (k == n - 1) ? TAIL : BODY;
            f.data.bt_pl = seed + 16'(k);
        end
        return f;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_cmd(input logic [1:0] x, input logic [1:0] y,
                            input logic [3:0] len, input logic [15:0] seed);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_x     = x;
        cmd_y     = y;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Samples at negedges; optionally drops on/off for stall_len cycles once
    // stall_after flits have been seen. first_lat counts negedges from c=1.
    task automatic collect(input int n, input logic [VC_NUM-1:0] on_base,
                           input int stall_after, input int stall_len,
                           output int first_lat, output int span);
        int c, last, stalled;
        c = 1; last = 0; stalled = 0; first_lat = -1;
        got_q.delete();
        while (got_q.size() < n && c < 200) begin
            if (is_valid_o) begin
                got_q.push_back(data_o);
                if (first_lat < 0) first_lat = c;
                last = c;
            end
            if (got_q.size() < n) begin
                if (got_q.size() == stall_after && stalled < stall_len) begin
                    is_on_off = '0;
                    stalled++;
                end else begin
                    is_on_off = on_base;
                end
                @(negedge clk);
                c++;
            end
        end
        is_on_off = on_base;
        check("flit_count", 64'(got_q.size()), 64'(n));
        span = last - first_lat + 1;
    endtask

    task automatic eject(input flit_label_t lbl, input logic [1:0] vc,
                         input logic [1:0] x, input logic [1:0] y);
        tb_ej_data                        = '0;
        tb_ej_data.flit_label             = lbl;
        tb_ej_data.vc_id                  = vc;
        tb_ej_data.data.head_data.x_dest  = x;
        tb_ej_data.data.head_data.y_dest  = y;
        tb_ej_valid                       = 1'b1;
        @(negedge clk);
        tb_ej_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   lat, span, seen, w;

        vecs[0] = '{2'd1, 2'd2, 4'd2,  16'h0005, 2, 16'h0006, TAIL};
        vecs[1] = '{2'd1, 2'd2, 4'd1,  16'h0ABC, 1, 16'h6ABC, HEADTAIL};
        vecs[2] = '{2'd1, 2'd2, 4'd0,  16'h0007, 1, 16'h6007, HEADTAIL};
        vecs[3] = '{2'd1, 2'd2, 4'd15, 16'hFFFE, 8, 16'h0005, TAIL};
        vecs[4] = '{2'd1, 2'd2, 4'd8,  16'h0100, 8, 16'h0107, TAIL};

        rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_len = '0; cmd_seed = '0;
        is_on_off = '1; is_allocatable = '1; tb_ej_data = '0; tb_ej_valid = 1'b0;
        sink_stall = 1'b0; loopback = 1'b1;

        // Reset state
        #3;
        check("rst_valid",     64'(is_valid_o),     64'd0);
        check("rst_data",      64'(data_o),         64'd0);
        check("rst_ready",     64'(cmd_ready),      64'd1);
        check("rst_tx",        64'(tx_pkt_cnt),     64'd0);
        check("rst_err",       64'(err),            64'd0);
        check("rst_ej_alloc",  64'(ej_allocatable), 64'hF);
        check("rst_ej_onoff",  64'(ej_on_off),      64'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: one packet per record, looped back into the sink
        for (int i = 0; i < 5; i++) begin
            send_cmd(vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].seed);
            collect(vecs[i].exp_n, 4'hF, -1, 0, lat, span);
            if (i == 0) check("head_latency", 64'(lat), 64'd3);
            check($sformatf("span_v%0d", i), 64'(span), 64'(vecs[i].exp_n));
            for (int k = 0; k < got_q.size(); k++)
                check($sformatf("flit_v%0d_k%0d", i, k), 64'(got_q[k]),
                      64'(model_flit(vecs[i].x, vecs[i].y, vecs[i].exp_n, vecs[i].seed, k, 2'd0)));
            if (got_q.size() > 0) begin
                check($sformatf("last_label_v%0d", i), 64'(got_q[got_q.size()-1].flit_label),
                      64'(vecs[i].exp_last_label));
                check($sformatf("last_data_v%0d", i), 64'(got_q[got_q.size()-1].data),
                      64'(vecs[i].exp_last_data));
            end
            check($sformatf("tx_cnt_v%0d", i), 64'(tx_pkt_cnt), 64'(i + 1));
        end
        @(negedge clk);
        @(negedge clk);
        check("tbl_rx_flit", 64'(rx_flit_cnt),    64'd20);
        check("tbl_rx_pkt",  64'(rx_pkt_cnt),     64'd5);
        check("tbl_err",     64'(err),            64'd0);
        check("tbl_ej_alloc",64'(ej_allocatable), 64'hF);

        // Hold in ALLOC for 3 cycles, then only vc2 allocatable; 2-cycle stall mid-packet
        is_allocatable = 4'b0000;
        send_cmd(2'd1, 2'd2, 4'd4, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("alloc_hold_valid%0d", i), 64'(is_valid_o), 64'd0);
            check($sformatf("alloc_hold_ready%0d", i), 64'(cmd_ready),  64'd0);
            @(negedge clk);
        end
        is_allocatable = 4'b0100;
        collect(4, 4'b0100, 2, 2, lat, span);
        check("stall_span", 64'(span), 64'd6);
        for (int k = 0; k < got_q.size(); k++)
            check($sformatf("vc2_flit%0d", k), 64'(got_q[k]),
                  64'(model_flit(2'd1, 2'd2, 4, 16'h0030, k, 2'd2)));
        check("vc2_tail_data", 64'(got_q.size() == 4 ? got_q[3].data : 16'h0), 64'h0033);
        check("vc2_tx", 64'(tx_pkt_cnt), 64'd6);
        is_allocatable = 4'hF;
        is_on_off      = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("vc2_rx_flit", 64'(rx_flit_cnt), 64'd24);
        check("vc2_err",     64'(err),         64'd0);

        // Sink: stall back-pressure, open flag, sticky errors
        loopback   = 1'b0;
        sink_stall = 1'b1;
        #1;
        check("stall_onoff", 64'(ej_on_off), 64'h0);
        @(negedge clk);
        eject(HEAD, 2'd0, 2'd1, 2'd2);
        check("open_alloc",     64'(ej_allocatable), 64'b1110);
        check("stall_rx_flit",  64'(rx_flit_cnt),    64'd25);
        sink_stall = 1'b0;
        #1;
        check("unstall_onoff",  64'(ej_on_off), 64'hF);
        @(negedge clk);
        eject(BODY, 2'd0, 2'd0, 2'd0);
        check("body_alloc",     64'(ej_allocatable), 64'b1110);
        check("body_err",       64'(err),            64'd0);
        eject(TAIL, 2'd0, 2'd0, 2'd0);
        check("tail_alloc",     64'(ej_allocatable), 64'hF);
        check("tail_rx_pkt",    64'(rx_pkt_cnt),     64'd7);
        eject(BODY, 2'd1, 2'd0, 2'd0);
        check("orphan_body_err", 64'(err), 64'b0010);
        @(negedge clk);
        @(negedge clk);
        check("err_sticky",      64'(err), 64'b0010);
        eject(HEAD, 2'd3, 2'd0, 2'd1);
        check("misroute_err",    64'(err), 64'b1010);
        check("sink_rx_flit",    64'(rx_flit_cnt), 64'd29);

        // Reset during flit 3 of an 8-flit packet
        loopback = 1'b1;
        send_cmd(2'd1, 2'd2, 4'd8, 16'h0200);
        seen = 0; w = 0;
        while (seen < 3 && w < 50) begin
            if (is_valid_o) seen++;
            if (seen < 3) begin
                @(negedge clk);
                w++;
            end
        end
        check("rst_reach_flit3", 64'(seen),       64'd3);
        check("pre_rst_valid",   64'(is_valid_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid",   64'(is_valid_o),     64'd0);
        check("mid_rst_data",    64'(data_o),         64'd0);
        check("mid_rst_ready",   64'(cmd_ready),      64'd1);
        check("mid_rst_tx",      64'(tx_pkt_cnt),     64'd0);
        check("mid_rst_rxf",     64'(rx_flit_cnt),    64'd0);
        check("mid_rst_rxp",     64'(rx_pkt_cnt),     64'd0);
        check("mid_rst_err",     64'(err),            64'd0);
        check("mid_rst_alloc",   64'(ej_allocatable), 64'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_cmd(2'd1, 2'd2, 4'd2, 16'h0040);
        collect(2, 4'hF, -1, 0, lat, span);
        check("post_rst_lat", 64'(lat), 64'd3);
        for (int k = 0; k < got_q.size(); k++)
            check($sformatf("post_rst_flit%0d", k), 64'(got_q[k]),
                  64'(model_flit(2'd1, 2'd2, 2, 16'h0040, k, 2'd0)));
        check("post_rst_tx", 64'(tx_pkt_cnt), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rxf", 64'(rx_flit_cnt), 64'd2);
        check("post_rst_rxp", 64'(rx_pkt_cnt),  64'd1);
        check("post_rst_err", 64'(err),         64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
